// File: rtl/disparity_sched.sv
// -----------------------------------------------------------------------------
// disparity_sched
//
// Purpose:
//   Sequences one stereo-matching pixel job at a time. For each accepted pixel
//   it issues MAX_DISP candidate disparities (0..MAX_DISP-1) to an external SAD
//   datapath. It then collects the SAD results, which come back SAD_LATENCY
//   cycles later, and keeps a running minimum. Finally it presents the winning
//   disparity with a valid/ready handshake.
//
// Ports:
//   clk              single clock, rising edge
//   rst              asynchronous, active-high reset
//   i_pix_valid      new pixel job offered
//   o_pix_ready      job accepted when high together with i_pix_valid
//   o_disp_sel       candidate disparity driving the second kernel
//   o_kernels_valid  o_disp_sel is a live candidate this cycle
//   o_sad_ready      pipeline enable for the SAD datapath
//   i_sad_data       SAD result; all-ones means invalid or saturated
//   o_disp_data      winning disparity
//   o_disp_valid     result valid
//   i_disp_ready     downstream accepts the result
//
// Configuration:
//   DISP_SCHED_INVALID_EN - when defined, a job whose candidates all return
//   all-ones reports o_disp_data = all-ones as an invalid marker. When it is
//   not defined, such a job reports disparity 0.
//
// States:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for a pixel job, o_pix_ready high
//   S_ISSUE  | issuing candidates 0..MAX_DISP-1, one per cycle
//   S_DRAIN  | waiting SAD_LATENCY cycles for the last results to return
//   S_OUTPUT | holding the winning disparity until i_disp_ready
// -----------------------------------------------------------------------------
module disparity_sched #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_DISP    = 64,
  parameter int SAD_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_pix_valid,
  output logic                        o_pix_ready,
  output logic [$clog2(MAX_DISP)-1:0] o_disp_sel,
  output logic                        o_kernels_valid,
  output logic                        o_sad_ready,
  input  logic [DATA_WIDTH-1:0]       i_sad_data,
  output logic [$clog2(MAX_DISP)-1:0] o_disp_data,
  output logic                        o_disp_valid,
  input  logic                        i_disp_ready
);

  localparam int DISP_WIDTH = $clog2(MAX_DISP);
  localparam int RET_WIDTH  = $clog2(MAX_DISP + 1);
  localparam int LAT_WIDTH  = $clog2(SAD_LATENCY + 1);

  localparam logic [DISP_WIDTH-1:0] LAST_DISP  = DISP_WIDTH'(MAX_DISP - 1);
  localparam logic [LAT_WIDTH-1:0]  LAST_DRAIN = LAT_WIDTH'(SAD_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DRAIN  = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  logic [DISP_WIDTH-1:0]   r_issue_cnt;
  logic [LAT_WIDTH-1:0]    r_drain_cnt;
  logic [RET_WIDTH-1:0]    r_ret_cnt;
  logic [SAD_LATENCY-1:0]  r_tag;
  logic [SAD_LATENCY-1:0]  w_tag_shift;
  logic                    w_tag_out;
  logic [DATA_WIDTH-1:0]   r_best;
  logic [DISP_WIDTH-1:0]   r_best_idx;
  logic [DISP_WIDTH-1:0]   w_result;
  logic                    w_accept;

  assign w_accept  = (r_state == S_IDLE) && i_pix_valid;
  assign w_tag_out = r_tag[SAD_LATENCY-1];

  // The tag register mirrors the SAD pipeline. A 1 at its output marks the
  // cycle in which i_sad_data belongs to a real candidate.
  generate
    if (SAD_LATENCY == 1) begin : g_tag_1
      assign w_tag_shift = o_kernels_valid;
    end else begin : g_tag_n
      assign w_tag_shift = {r_tag[SAD_LATENCY-2:0], o_kernels_valid};
    end
  endgenerate

`ifdef DISP_SCHED_INVALID_EN
  // best still all-ones means no candidate produced a usable SAD.
  assign w_result = (r_best == '1) ? '1 : r_best_idx;
`else
  assign w_result = r_best_idx;
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state    = r_state;
    o_pix_ready     = 1'b0;
    o_kernels_valid = 1'b0;
    o_sad_ready     = 1'b0;
    o_disp_valid    = 1'b0;
    o_disp_sel      = '0;
    o_disp_data     = '0;

    case (r_state)
      S_IDLE: begin
        // Reset already forces S_IDLE. Gating with rst keeps ready low
        // while reset is still held.
        o_pix_ready = ~rst;
        if (i_pix_valid) begin
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_kernels_valid = 1'b1;
        o_sad_ready     = 1'b1;
        o_disp_sel      = r_issue_cnt;
        if (r_issue_cnt == LAST_DISP) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_sad_ready = 1'b1;
        if (r_drain_cnt == LAST_DRAIN) begin
          w_next_state = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        o_disp_valid = 1'b1;
        o_disp_data  = w_result;
        if (i_disp_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters, valid tags and running minimum
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_cnt <= '0;
      r_drain_cnt <= '0;
      r_ret_cnt   <= '0;
      r_tag       <= '0;
      r_best      <= '1;
      r_best_idx  <= '0;
    end else begin
      if (w_accept) begin
        r_issue_cnt <= '0;
        r_drain_cnt <= '0;
        r_ret_cnt   <= '0;
        r_best      <= '1;
        r_best_idx  <= '0;
      end

      if (r_state == S_ISSUE) begin
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end

      if (r_state == S_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 1'b1;
      end

      if (o_sad_ready) begin
        r_tag <= w_tag_shift;
      end

      // Results return in issue order, so the return counter is the
      // disparity of the SAD on i_sad_data. A strict compare keeps the
      // lowest disparity on a tie.
      if (w_tag_out) begin
        r_ret_cnt <= r_ret_cnt + 1'b1;
        if (i_sad_data < r_best) begin
          r_best     <= i_sad_data;
          r_best_idx <= r_ret_cnt[DISP_WIDTH-1:0];
        end
      end
    end
  end

`ifndef SYNTHESIS
  // Every issued candidate must have returned before the result is shown.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_OUTPUT) begin
      assert (r_ret_cnt == RET_WIDTH'(MAX_DISP));
    end
  end
`endif

endmodule
